// File: rtl/reorder_buffer_wp2.sv
// Reorder buffer feeding a 2-write-port register file.
// Up to two allocations per cycle at the tail and out-of-order completion by tag.
// The two oldest completed entries retire per cycle, in program order.

// One buffer slot: valid/done flags plus the latched destination and result.
module reorder_buffer_wp2_entry #(
  parameter int SIZE = 32,
  parameter int REGW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [REGW-1:0] alloc_dest,
  input  logic            done_en,
  input  logic [SIZE-1:0] done_data,
  input  logic            clr,
  output logic            vld,
  output logic            dn,
  output logic [REGW-1:0] dest,
  output logic [SIZE-1:0] data
);
  // Alloc only hits free slots and clr only hits done slots, so the order below
  // matters only for flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dn   <= 1'b0;
      dest <= '0;
      data <= '0;
    end else if (flush || clr) begin
      vld <= 1'b0;
      dn  <= 1'b0;
    end else if (alloc_en) begin
      vld  <= 1'b1;
      dn   <= 1'b0;
      dest <= alloc_dest;
    end else if (done_en) begin
      dn   <= 1'b1;
      data <= done_data;
    end
  end
endmodule

module reorder_buffer_wp2 #(
  parameter  int SIZE    = 32,
  parameter  int REG_NUM = 8,
  parameter  int ENTRIES = 8,
  localparam int REGW    = $clog2(REG_NUM),
  localparam int TAGW    = $clog2(ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [1:0]                alloc_valid,
  input  logic [1:0][REGW-1:0]      alloc_dest,
  output logic                      alloc_ready,
  output logic [1:0][TAGW-1:0]      alloc_tag,
  input  logic [1:0]                done_valid,
  input  logic [1:0][TAGW-1:0]      done_tag,
  input  logic [1:0][SIZE-1:0]      done_data,
  output logic [1:0]                RegWrite,
  output logic [1:0][REGW-1:0]      write_reg,
  output logic [1:0][SIZE-1:0]      write_data,
  output logic [TAGW:0]             count,
  output logic                      empty
);
  logic [ENTRIES-1:0]           vld, dn;
  logic [ENTRIES-1:0][REGW-1:0] dst;
  logic [ENTRIES-1:0][SIZE-1:0] dat;
  logic [TAGW-1:0]              head, tail, head1, tail1;
  logic [TAGW:0]                cnt, n_acc, n_cmt;
  logic [1:0]                   acc, dok;
  logic                         c0, c1;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  assign count = cnt;
  assign empty = (cnt == '0);

  // Two free slots required so a full pair can always be taken.
  assign alloc_ready = (cnt < (TAGW+1)'(ENTRIES-1));

  // Lanes are compacted: lane 1 only takes tail+1 when lane 0 is also allocating.
  assign alloc_tag[0] = tail;
  assign alloc_tag[1] = alloc_valid[0] ? tail1 : tail;

  assign acc   = alloc_ready ? alloc_valid : 2'b00;
  assign n_acc = (TAGW+1)'(acc[0]) + (TAGW+1)'(acc[1]);

  // Completion lands only on a live, not-yet-done slot; lane 0 wins a tag collision.
  assign dok[0] = done_valid[0] & vld[done_tag[0]] & ~dn[done_tag[0]];
  assign dok[1] = done_valid[1] & vld[done_tag[1]] & ~dn[done_tag[1]]
                & ~(done_valid[0] & (done_tag[0] == done_tag[1]));

  // Lane 1 retires only behind lane 0 to keep program order.
  assign c0    = vld[head] & dn[head];
  assign c1    = c0 & vld[head1] & dn[head1];
  assign n_cmt = (TAGW+1)'(c0) + (TAGW+1)'(c1);

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    localparam logic [TAGW-1:0] E = TAGW'(e);
    logic a0, a1, d0, d1, cl;
    assign a0 = acc[0] & (alloc_tag[0] == E);
    assign a1 = acc[1] & (alloc_tag[1] == E);
    assign d0 = dok[0] & (done_tag[0] == E);
    assign d1 = dok[1] & (done_tag[1] == E);
    assign cl = (c0 & (head == E)) | (c1 & (head1 == E));

    reorder_buffer_wp2_entry #(.SIZE(SIZE), .REGW(REGW)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .alloc_en  (a0 | a1),
      .alloc_dest(a0 ? alloc_dest[0] : alloc_dest[1]),
      .done_en   (d0 | d1),
      .done_data (d0 ? done_data[0] : done_data[1]),
      .clr       (cl),
      .vld       (vld[e]),
      .dn        (dn[e]),
      .dest      (dst[e]),
      .data      (dat[e])
    );
  end

  // Pointer/occupancy bookkeeping and the registered register-file write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      RegWrite   <= '0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      RegWrite   <= '0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      head          <= head + n_cmt[TAGW-1:0];
      tail          <= tail + n_acc[TAGW-1:0];
      cnt           <= cnt + n_acc - n_cmt;
      RegWrite      <= {c1, c0};
      write_reg[0]  <= c0 ? dst[head]  : '0;
      write_reg[1]  <= c1 ? dst[head1] : '0;
      write_data[0] <= c0 ? dat[head]  : '0;
      write_data[1] <= c1 ? dat[head1] : '0;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_wp2.sv
// Bench for reorder_buffer_wp2: a queue of in-flight instructions in program
// order is the reference; a negedge monitor retires from it and compares.
module tb_reorder_buffer_wp2;
  localparam int SIZE = 32, REG_NUM = 8, ENTRIES = 8;
  localparam int REGW = $clog2(REG_NUM), TAGW = $clog2(ENTRIES);

  logic                 clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [1:0]           alloc_valid = '0;
  logic [1:0][REGW-1:0] alloc_dest = '0;
  logic                 alloc_ready;
  logic [1:0][TAGW-1:0] alloc_tag;
  logic [1:0]           done_valid = '0;
  logic [1:0][TAGW-1:0] done_tag = '0;
  logic [1:0][SIZE-1:0] done_data = '0;
  logic [1:0]           RegWrite;
  logic [1:0][REGW-1:0] write_reg;
  logic [1:0][SIZE-1:0] write_data;
  logic [TAGW:0]        count;
  logic                 empty;

  reorder_buffer_wp2 dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // In-flight instruction: done_edge is the posedge index at which its result landed.
  typedef struct {
    int              seq;
    logic [TAGW-1:0] tag;
    logic [REGW-1:0] dest;
    logic [SIZE-1:0] data;
    int              done_edge;
  } ent_t;

  ent_t            q[$];
  int              seq = 0;
  int              cyc = 0;
  int              n_chk = 0, n_pass = 0;
  logic [SIZE-1:0] rf [REG_NUM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: oldest up-to-two entries completed before this edge must retire now.
  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      k = 0;
      while (k < 2 && k < q.size() && q[k].done_edge >= 0 && q[k].done_edge < cyc) k++;
      chk("regwrite", 64'(RegWrite), (k == 2) ? 64'd3 : (k == 1) ? 64'd1 : 64'd0);
      for (int l = 0; l < 2; l++) begin
        if (l < k) begin
          chk("write_reg", 64'(write_reg[l]), 64'(q[l].dest));
          chk("write_data", 64'(write_data[l]), 64'(q[l].data));
        end else begin
          chk("write_reg_idle", 64'(write_reg[l]), 64'd0);
          chk("write_data_idle", 64'(write_data[l]), 64'd0);
        end
      end
      for (int l = 0; l < k; l++) begin
        rf[q[0].dest] = q[0].data;
        void'(q.pop_front());
      end
      chk("count", 64'(count), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("alloc_ready", 64'(alloc_ready), 64'(q.size() <= ENTRIES - 2));
      chk("alloc_tag0", 64'(alloc_tag[0]), 64'(seq % ENTRIES));
      chk("alloc_tag1", 64'(alloc_tag[1]), 64'((seq + (alloc_valid[0] ? 1 : 0)) % ENTRIES));
    end
  end

  // Drive one cycle and update the reference with what the buffer must accept.
  task automatic step(input logic [1:0] av, input logic [REGW-1:0] ad0, input logic [REGW-1:0] ad1,
                      input logic [1:0] dv, input logic [TAGW-1:0] dt0, input logic [TAGW-1:0] dt1,
                      input logic [SIZE-1:0] dd0, input logic [SIZE-1:0] dd1, input logic fl);
    bit   rdy;
    ent_t e;
    @(negedge clk); #1;
    alloc_valid = av; alloc_dest[0] = ad0; alloc_dest[1] = ad1;
    done_valid = dv; done_tag[0] = dt0; done_tag[1] = dt1;
    done_data[0] = dd0; done_data[1] = dd1; flush = fl;
    if (fl) begin
      q.delete();
      seq = 0;
    end else begin
      rdy = (q.size() <= ENTRIES - 2);
      // completions first: entries allocated this cycle are not yet live
      for (int l = 0; l < 2; l++)
        if (dv[l])
          foreach (q[i])
            if (q[i].tag == (l ? dt1 : dt0) && q[i].done_edge < 0) begin
              q[i].done_edge = cyc + 1;
              q[i].data = l ? dd1 : dd0;
            end
      if (rdy)
        for (int l = 0; l < 2; l++)
          if (av[l]) begin
            e.seq = seq; e.tag = TAGW'(seq % ENTRIES); e.dest = l ? ad1 : ad0;
            e.data = '0; e.done_edge = -1;
            q.push_back(e);
            seq++;
          end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [TAGW-1:0] tg(input int s);
    return TAGW'(s % ENTRIES);
  endfunction

  // Complete everything outstanding and wait for the buffer to empty, bounded.
  task automatic drain(input int budget);
    while (q.size() > 0 && budget > 0) begin
      logic [1:0]      dv;
      logic [TAGW-1:0] t0, t1;
      int              n;
      dv = 0; t0 = 0; t1 = 0; n = 0;
      foreach (q[i])
        if (q[i].done_edge < 0 && n < 2) begin
          if (n == 0) t0 = q[i].tag; else t1 = q[i].tag;
          dv[n] = 1'b1;
          n++;
        end
      step(2'b00, '0, '0, dv, t0, t1, $urandom, $urandom, 1'b0);
      budget--;
    end
    idle(1);
    chk("drain_count", 64'(count), 64'd0);
  endtask

  task automatic rand_step();
    logic [1:0]      av, dv;
    logic [REGW-1:0] d0, d1;
    logic [TAGW-1:0] t0, t1;
    logic            fl;
    int              und[$];
    bit              used[ENTRIES];
    int              r, off;
    av = 2'($urandom_range(0, 3));
    d0 = REGW'($urandom); d1 = REGW'($urandom);
    dv = 0; t0 = 0; t1 = 0;
    fl = ($urandom_range(0, 99) == 0);
    foreach (used[i]) used[i] = 0;
    foreach (q[i]) begin
      used[q[i].tag] = 1;
      if (q[i].done_edge < 0) und.push_back(i);
    end
    if (und.size() > 0 && $urandom_range(0, 2) != 0) begin
      dv[0] = 1'b1;
      t0 = q[und[$urandom_range(0, und.size() - 1)]].tag;
    end
    r = $urandom_range(0, 7);
    if (r == 0) begin
      dv[1] = 1'b1; t1 = t0;
    end else if (r == 1) begin
      off = $urandom_range(0, ENTRIES - 1);
      for (int i = 0; i < ENTRIES; i++)
        if (!dv[1] && !used[(i + off) % ENTRIES]) begin
          dv[1] = 1'b1; t1 = TAGW'((i + off) % ENTRIES);
        end
    end else if (r == 2 && q.size() > 0) begin
      dv[1] = 1'b1; t1 = q[$urandom_range(0, q.size() - 1)].tag;
    end else if (und.size() > 0) begin
      dv[1] = 1'b1; t1 = q[und[$urandom_range(0, und.size() - 1)]].tag;
    end
    step(av, d0, d1, dv, t0, t1, $urandom, $urandom, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, ps, s0;
    foreach (rf[i]) rf[i] = '0;
    // reset state
    @(negedge clk); #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    @(negedge clk); #1 rst_n = 1'b1;

    // basic pair: dest 3/5 completed together
    b = seq;
    step(2'b11, 3'd3, 3'd5, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b11, tg(b), tg(b + 1), 32'h11, 32'h22, 1'b0);
    idle(3);

    // out-of-order completion
    b = seq;
    step(2'b11, 3'd1, 3'd2, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b01, 3'd6, 3'd0, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b01, tg(b + 2), '0, 32'h202, '0, 1'b0);
    step(2'b00, '0, '0, 2'b01, tg(b + 1), '0, 32'h201, '0, 1'b0);
    idle(2);
    step(2'b00, '0, '0, 2'b01, tg(b), '0, 32'h200, '0, 1'b0);
    idle(4);

    // fill to 7, attempt dropped allocs, then free one
    b = seq;
    for (int i = 0; i < 3; i++) step(2'b11, 3'(i), 3'(i + 1), 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b01, 3'd7, 3'd0, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b11, 3'd2, 3'd3, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b11, 3'd2, 3'd3, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b01, tg(b), '0, 32'h300, '0, 1'b0);
    idle(3);
    drain(40);

    // sustained pairs across the pointer wrap, value = 0x100 + sequence
    ps = seq; b = seq;
    for (int i = 0; i < 20; i++) begin
      s0 = seq;
      step(2'b11, 3'(i), 3'(i + 3), (i > 0) ? 2'b11 : 2'b00, tg(ps), tg(ps + 1),
           32'h100 + 32'(ps - b), 32'h100 + 32'(ps - b + 1), 1'b0);
      ps = s0;
    end
    step(2'b00, '0, '0, 2'b11, tg(ps), tg(ps + 1), 32'h100 + 32'(ps - b), 32'h100 + 32'(ps - b + 1), 1'b0);
    drain(40);

    // same destination on both lanes: younger value must land last
    b = seq;
    step(2'b11, 3'd4, 3'd4, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b11, tg(b), tg(b + 1), 32'hAAAA, 32'hBBBB, 1'b0);
    idle(3);
    chk("rf_same_dest", 64'(rf[4]), 64'hBBBB);

    // randomized traffic
    for (int i = 0; i < 400; i++) rand_step();
    drain(64);

    // flush with 4 pending (2 younger ones done) plus a same-cycle alloc
    b = seq;
    step(2'b11, 3'd1, 3'd2, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b11, 3'd3, 3'd4, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b11, tg(b + 2), tg(b + 3), 32'h55, 32'h66, 1'b0);
    step(2'b11, 3'd5, 3'd6, 2'b00, '0, '0, '0, '0, 1'b1);
    @(negedge clk); #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_regwrite", 64'(RegWrite), 64'd0);
    chk("flush_tag0", 64'(alloc_tag[0]), 64'd0);
    idle(2);

    // asynchronous reset while a commit is on the write ports
    step(2'b11, 3'd1, 3'd2, 2'b00, '0, '0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 2'b11, 3'd0, 3'd1, 32'h77, 32'h88, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_regwrite", 64'(RegWrite), 64'd3);
    rst_n = 1'b0;
    alloc_valid = '0; done_valid = '0;
    q.delete(); seq = 0;
    #1;
    chk("async_rst_regwrite", 64'(RegWrite), 64'd0);
    chk("async_rst_write_reg", 64'(write_reg), 64'd0);
    chk("async_rst_write_data", 64'(write_data), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    @(negedge clk); #1 rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_wp2.md
Name: reorder_buffer_wp2

Overview:
- In-order commit buffer for the dual-issue datapath; sits directly upstream of the 2-write-port register file.
- Dispatch allocates up to 2 entries per cycle. Execution units complete entries out of order via tag.
- Up to 2 oldest completed entries retire per cycle onto RegWrite/write_reg/write_data, which connect 1:1 to the register file write ports.

Parameters:
- SIZE, 32, data width of a register value
- REG_NUM, 8, architectural register count; REGW = $clog2(REG_NUM)
- ENTRIES, 8, buffer depth, power of two; TAGW = $clog2(ENTRIES)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- alloc_valid  in  [1:0]  allocation request per lane
- alloc_dest  in  [1:0][REGW-1:0]  destination register per lane
- alloc_ready  out  1  high when free entries >= 2
- alloc_tag  out  [1:0][TAGW-1:0]  tag granted per lane, combinational from tail
- done_valid  in  [1:0]  completion strobe per lane
- done_tag  in  [1:0][TAGW-1:0]  completing entry tag
- done_data  in  [1:0][SIZE-1:0]  result value
- RegWrite  out  [1:0]  commit strobe per write port, registered
- write_reg  out  [1:0][REGW-1:0]  committed destination, registered
- write_data  out  [1:0][SIZE-1:0]  committed value, registered
- count  out  [TAGW:0]  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, async):
  - head, tail, count = 0; all valid/done bits = 0.
  - RegWrite, write_reg, write_data = 0; alloc_ready = 1; empty = 1.
- Entry state: valid, done, dest, data. Storage is circular; head/tail wrap modulo ENTRIES.
- Allocation:
  - Accepted only when alloc_ready = 1. alloc_ready is computed from count before the current cycle's commits.
  - Lanes are compacted. The lowest valid lane takes tail; a second valid lane takes tail+1.
  - alloc_tag[0] = tail. alloc_tag[1] = tail+1 if alloc_valid[0], else tail.
  - Accepted entry: valid = 1, done = 0, dest latched; tail advances by the number of accepted lanes.
  - alloc_valid while alloc_ready = 0 is dropped. Upstream must hold the request.
- Completion:
  - done_valid[i] to an entry with valid = 1 and done = 0 sets done = 1 and data = done_data[i].
  - A done_valid to an invalid entry, or to an already-done entry, is ignored.
  - Both lanes targeting the same tag: lane 0 wins, lane 1 is ignored.
- Commit, evaluated on registered state:
  - c0 = valid[head] & done[head].
  - c1 = c0 & valid[head+1] & done[head+1].
  - At posedge: RegWrite <= {c1, c0}; write_reg/write_data <= entry dest/data for the committing lanes, 0 for non-committing lanes.
  - Committed entries are cleared; head advances by c0 + c1.
  - Lane 1 never commits without lane 0, which preserves program order.
  - Same dest on both lanes: lane 1 is the younger entry. The register file writes port 1 last, so the younger value wins.
- Latency:
  - done_valid sampled at edge N; RegWrite high from edge N+1 to edge N+2. The register file captures on the negedge within that window.
  - Allocation to earliest commit: 2 edges.
- Simultaneous events:
  - Alloc, completion and commit may occur in the same cycle.
  - count_next = count + accepted − committed.
  - Completion to an entry being allocated in the same cycle is ignored (that entry is not yet valid).
- Full / wrap:
  - count == ENTRIES forces alloc_ready = 0.
  - count == ENTRIES−1 also forces alloc_ready = 0 (conservative 2-wide rule).
  - Pointer wrap is seamless; tags are reused only after commit.
- flush:
  - Highest priority. At the posedge it clears all valid/done bits; head = tail = count = 0; RegWrite <= 0.
  - Same-cycle alloc, done and commit are all discarded.
- Reset mid-operation: asynchronous return to reset values; no commit is emitted.

Test Plan:
- Reset, alloc lanes {dest 3, dest 5}: tags {0,1}, count = 2. Complete both at edge N: RegWrite = 2'b11, write_reg = {5,3} after edge N+1, empty = 1 after.
- Out-of-order: alloc tags 0,1,2. Complete tag 2, then tag 1: RegWrite stays 0. Complete tag 0: next commit cycle RegWrite = 2'b11 (tags 0,1), following cycle RegWrite = 2'b01 (tag 2).
- Fill: 3 alloc pairs plus 1 single (count = 7): alloc_ready = 0, further alloc_valid dropped, count stays 7. One commit restores alloc_ready = 1.
- Wrap: sustain 20 alloc/complete pairs with ENTRIES = 8. Tags wrap 7 → 0; commit order and write_data (value = 0x100 + sequence) are monotonic, none lost or duplicated.
- Same dest: lanes both dest 4, data 0xAAAA (older) / 0xBBBB (younger), completed together: RegWrite = 2'b11. Register file reads 0xBBBB.
- Flush with 4 entries pending, 2 done, plus a same-cycle alloc: next cycle count = 0, RegWrite = 0, alloc_tag[0] = 0. Then assert rst_n low mid-commit: outputs 0 immediately, without waiting for a clock.
